aud_sram_arbiter: RTL

//  Single-port SRAM controller/arbiter for the audio recorder/player. Shares the external 1M x 16 SRAM

---
 rtl/aud_sram_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/aud_sram_arbiter.sv
// Single-port SRAM controller shared by the recorder (writes) and the player (reads).
// Fixed-length read/write pin sequencing, read priority with a write starvation limit, recording end tracking.
module aud_sram_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int RD_CYC   = 2,
  parameter int WR_CYC   = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_gnt,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_gnt,
  output logic              o_wr_done,
  input  logic              i_clr_end,
  output logic [ADDR_W-1:0] o_rec_end_addr,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam int MAX_CYC = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int CYC_W   = $clog2(MAX_CYC);
  localparam int WAIT_W  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [CYC_W-1:0]  RD_LAST  = CYC_W'(RD_CYC - 1);
  localparam logic [CYC_W-1:0]  WR_LAST  = CYC_W'(WR_CYC - 1);
  localparam logic [CYC_W-1:0]  WE_OFF   = CYC_W'(WR_CYC - 2);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t            state;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wr_wins;
  logic              rd_wins;

  // Arbitration outcome, only acted on in S_IDLE.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    wr_wins = 1'b0;
    rd_wins = 1'b0;
    if (i_wr_req && (!i_rd_req || wait_cnt >= WAIT_LIM)) wr_wins = 1'b1;
    else if (i_rd_req)                                   rd_wins = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments; the last assignment in the block wins,
  // which is how a clear of the end address overrides a same-edge write-completion update.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= S_IDLE;
      cyc_cnt        <= '0;
      wait_cnt       <= '0;
      o_rd_gnt       <= 1'b0;
      o_rd_valid     <= 1'b0;
      o_rd_data      <= '0;
      o_wr_gnt       <= 1'b0;
      o_wr_done      <= 1'b0;
      o_rec_end_addr <= '0;
      o_busy         <= 1'b0;
      o_sram_addr    <= '0;
      o_sram_dq      <= '0;
      o_sram_dq_oe   <= 1'b0;
      o_sram_ce_n    <= 1'b1;
      o_sram_oe_n    <= 1'b1;
      o_sram_we_n    <= 1'b1;
      o_sram_lb_n    <= 1'b1;
      o_sram_ub_n    <= 1'b1;
    end else begin
      o_rd_gnt   <= 1'b0;
      o_rd_valid <= 1'b0;
      o_wr_gnt   <= 1'b0;
      o_wr_done  <= 1'b0;

      // Counts arbitrations a pending write lost to a read; saturates at the limit.
      if (!i_wr_req || (state == S_IDLE && wr_wins))
        wait_cnt <= '0;
      else if (state == S_IDLE && rd_wins && wait_cnt != WAIT_LIM)
        wait_cnt <= wait_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          cyc_cnt <= '0;
          if (wr_wins) begin
            state        <= S_WR;
            o_wr_gnt     <= 1'b1;
            o_busy       <= 1'b1;
            o_sram_addr  <= i_wr_addr;
            o_sram_dq    <= i_wr_data;
            o_sram_dq_oe <= 1'b1;
            o_sram_ce_n  <= 1'b0;
            o_sram_oe_n  <= 1'b1;
            o_sram_we_n  <= 1'b0;
            o_sram_lb_n  <= 1'b0;
            o_sram_ub_n  <= 1'b0;
          end else if (rd_wins) begin
            state        <= S_RD;
            o_rd_gnt     <= 1'b1;
            o_busy       <= 1'b1;
            o_sram_addr  <= i_rd_addr;
            o_sram_dq_oe <= 1'b0;
            o_sram_ce_n  <= 1'b0;
            o_sram_oe_n  <= 1'b0;
            o_sram_we_n  <= 1'b1;
            o_sram_lb_n  <= 1'b0;
            o_sram_ub_n  <= 1'b0;
          end
        end

        S_RD: begin
          if (cyc_cnt == RD_LAST) begin
            state       <= S_IDLE;
            o_rd_data   <= i_sram_dq;
            o_rd_valid  <= 1'b1;
            o_busy      <= 1'b0;
            o_sram_ce_n <= 1'b1;
            o_sram_oe_n <= 1'b1;
            o_sram_lb_n <= 1'b1;
            o_sram_ub_n <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        S_WR: begin
          if (cyc_cnt == WR_LAST) begin
            state        <= S_IDLE;
            o_wr_done    <= 1'b1;
            o_busy       <= 1'b0;
            o_sram_dq_oe <= 1'b0;
            o_sram_ce_n  <= 1'b1;
            o_sram_lb_n  <= 1'b1;
            o_sram_ub_n  <= 1'b1;
            if (o_sram_addr > o_rec_end_addr) o_rec_end_addr <= o_sram_addr;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            // WE_N rises one cycle early so data is held past the write strobe.
            if (cyc_cnt == WE_OFF) o_sram_we_n <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase

      if (i_clr_end) o_rec_end_addr <= '0;
    end
  end

endmodule
